// File: rtl/div_unit.sv
// div_unit: iterative restoring divider, one quotient bit per cycle, signed or unsigned,
// with start/busy/done handshake and flush cancel.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             flush,
    input  logic             Sign,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t           r_state, w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_rem, r_quo, r_div;
    logic             r_neg_q, r_neg_r;
    logic             w_a_neg, w_b_neg;
    logic [WIDTH:0]   w_shift, w_diff;

    assign busy    = (r_state != IDLE);
    assign w_a_neg = Sign & dividend[WIDTH-1];
    assign w_b_neg = Sign & divisor[WIDTH-1];
    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_div};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = IDLE;
        if (!flush)
            w_next = (r_state == IDLE) ? (start ? CALC : IDLE) :
                     (r_state == CALC) ? ((r_cnt == CW'(WIDTH - 1)) ? FIX : CALC) : IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_div     <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (r_state == IDLE && w_next == CALC) begin
                r_cnt   <= '0;
                r_rem   <= '0;
                r_quo   <= w_a_neg ? -dividend : dividend;
                r_div   <= w_b_neg ? -divisor : divisor;
                // a zero divisor must yield all ones regardless of operand signs
                r_neg_q <= (w_a_neg ^ w_b_neg) & (|divisor);
                r_neg_r <= w_a_neg;
            end else if (r_state == CALC && w_next != IDLE) begin
                r_cnt <= r_cnt + CW'(1);
                r_rem <= w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
                r_quo <= {r_quo[WIDTH-2:0], ~w_diff[WIDTH]};
            end else if (r_state == FIX && !flush) begin
                quotient  <= r_neg_q ? -r_quo : r_quo;
                remainder <= r_neg_r ? -r_rem : r_rem;
                done      <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: randomized and directed checks of div_unit against a cycle-count/arithmetic model.
module tb_div_unit;
    localparam int WIDTH = 32;

    logic             clk, reset, start, flush, Sign;
    logic [WIDTH-1:0] dividend, divisor, quotient, remainder;
    logic             busy, done;

    int errors = 0;
    int checks = 0;

    div_unit #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .start(start), .flush(flush), .Sign(Sign),
        .dividend(dividend), .divisor(divisor), .quotient(quotient),
        .remainder(remainder), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: truncating division, remainder follows dividend.
    function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q, r;
        if (b == 0) begin
            q = '1;
            r = a;
        end else if (s) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = a;
                r = 0;
            end else begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end
        end else begin
            q = a / b;
            r = a % b;
        end
        return {q, r};
    endfunction

    // Model: a divide launched on an edge completes WIDTH+1 edges later unless flushed.
    logic        m_active, m_done;
    int          m_cnt;
    logic [31:0] m_q, m_r, p_q, p_r;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_active <= 1'b0;
            m_done   <= 1'b0;
            m_cnt    <= 0;
            m_q      <= 0;
            m_r      <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_active) begin
                if (flush) m_active <= 1'b0;
                else if (m_cnt == WIDTH) begin
                    m_active <= 1'b0;
                    m_done   <= 1'b1;
                    m_q      <= p_q;
                    m_r      <= p_r;
                end else m_cnt <= m_cnt + 1;
            end else if (start && !flush) begin
                m_active   <= 1'b1;
                m_cnt      <= 0;
                {p_q, p_r} <= ref_div(Sign, dividend, divisor);
            end
        end
    end

    always @(negedge clk) begin
        chk("cyc_busy", 32'(busy), 32'(m_active));
        chk("cyc_done", 32'(done), 32'(m_done));
        chk("cyc_quot", quotient, m_q);
        chk("cyc_rem", remainder, m_r);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b);
        Sign = s;
        dividend = a;
        divisor = b;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output int n, output int nb);
        n = 0;
        nb = 0;
        while (!done && n < 100) begin
            nb += int'(busy);
            tick();
            n++;
        end
        chk("done_seen", 32'(done), 32'd1);
    endtask

    task automatic run_lit(input logic s, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] q, input logic [31:0] r);
        int n, nb;
        launch(s, a, b);
        wait_done(n, nb);
        chk("latency", n, WIDTH + 1);
        chk("busy_cycles", nb, WIDTH + 1);
        chk("lit_quot", quotient, q);
        chk("lit_rem", remainder, r);
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] corners [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        int k = $urandom_range(0, 9);
        return (k < 5) ? corners[k] : (k < 7) ? 32'($urandom_range(1, 20)) : $urandom;
    endfunction

    initial begin
        int n, nb, dc;
        reset = 1'b0; start = 1'b0; flush = 1'b0; Sign = 1'b0;
        dividend = 0; divisor = 0;
        #1 reset = 1'b1;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_quot", quotient, 0);
        chk("rst_rem", remainder, 0);
        reset = 1'b0;
        tick();

        run_lit(1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
        run_lit(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run_lit(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
        run_lit(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
        run_lit(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
        run_lit(1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5);
        run_lit(1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB);

        // start during busy is ignored
        launch(1'b0, 32'd50, 32'd3);
        repeat (9) tick();
        Sign = 1'b0; dividend = 32'd1000; divisor = 32'd10; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(n, nb);
        chk("ign_quot", quotient, 32'd16);
        chk("ign_rem", remainder, 32'd2);

        // start in the done cycle is accepted
        launch(1'b0, 32'd9, 32'd3);
        chk("b2b_busy", 32'(busy), 1);
        wait_done(n, nb);
        chk("b2b_latency", n, WIDTH + 1);
        chk("b2b_quot", quotient, 32'd3);
        chk("b2b_rem", remainder, 32'd0);

        // flush cancels without a done pulse
        launch(1'b0, 32'd100, 32'd7);
        repeat (14) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_busy", 32'(busy), 0);
        dc = 0;
        repeat (40) begin
            tick();
            dc += int'(done);
        end
        chk("flush_no_done", dc, 0);
        chk("flush_quot", quotient, 32'd3);
        chk("flush_rem", remainder, 32'd0);
        run_lit(1'b0, 32'd20, 32'd7, 32'd2, 32'd6);

        // flush beats start in idle
        Sign = 1'b0; dividend = 32'd8; divisor = 32'd2; start = 1'b1; flush = 1'b1;
        tick();
        start = 1'b0; flush = 1'b0;
        chk("prio_busy", 32'(busy), 0);
        tick();

        for (int i = 0; i < 150; i++) begin
            launch(1'($urandom_range(0, 1)), pick(), pick());
            wait_done(n, nb);
            chk("rnd_latency", n, WIDTH + 1);
            repeat ($urandom_range(0, 2)) tick();
        end

        // async reset mid-calc
        run_lit(1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
        launch(1'b0, 32'd77, 32'd5);
        repeat (10) tick();
        #2 reset = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_done", 32'(done), 0);
        chk("arst_quot", quotient, 0);
        chk("arst_rem", remainder, 0);
        tick();
        reset = 1'b0;
        tick();
        run_lit(1'b0, 32'd77, 32'd5, 32'd15, 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
